// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and stage-count helper.
// Optional rotate support is selected with the SHIFTER_ROTATE_EN macro.
package shifter_pkg;

  typedef logic [1:0] sh_op_t;

  localparam sh_op_t SH_OP_SLL = 2'b00;
  localparam sh_op_t SH_OP_SRL = 2'b01;
  localparam sh_op_t SH_OP_SRA = 2'b10;
  localparam sh_op_t SH_OP_ROR = 2'b11;

  // Number of pipeline registers needed to cover shamt_w mux levels, lps levels per stage.
  function automatic int unsigned calc_nstage(input int unsigned shamt_w,
                                              input int unsigned lps);
    return (shamt_w + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the barrel shifter, shifting by DIST when sel is set.
// Rotate wrap-around is only built when SHIFTER_ROTATE_EN is defined; otherwise op 11 acts as SRL.
module shift_level
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             sel,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shifted;

  // Top DIST bits set: the positions vacated by a right shift.
  assign fill_mask = ~({WIDTH{1'b1}} >> DIST);

  always_comb begin
    shifted = din >> DIST;
    case (op)
      SH_OP_SLL: shifted = din << DIST;
      SH_OP_SRA: shifted = (din >> DIST) | (fill_mask & {WIDTH{sign}});
`ifdef SHIFTER_ROTATE_EN
      SH_OP_ROR: shifted = (din >> DIST) | (din << (WIDTH - DIST));
`endif
      default:   shifted = din >> DIST;
    endcase
    dout = sel ? shifted : din;
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with a global-stall valid/ready handshake.
// Rotate is enabled by SHIFTER_ROTATE_EN; without it op 11 behaves as SRL.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned SHAMT_W          = $clog2(WIDTH),
  parameter int unsigned LEVELS_PER_STAGE = 2,
  parameter int unsigned TAG_W            = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned NSTAGE = calc_nstage(SHAMT_W, LEVELS_PER_STAGE);

  logic advance;

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    // Shift-amount bits still unconsumed when entering this stage.
    localparam int unsigned WS = SHAMT_W - s * LEVELS_PER_STAGE;

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic [WS-1:0]    src_shamt;
    logic [1:0]       src_op;
    logic             src_sign;
    logic [TAG_W-1:0] src_tag;
    logic [WIDTH-1:0] chain [LEVELS_PER_STAGE+1];

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [TAG_W-1:0] tag_q;

    if (s == 0) begin : g_src_in
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_shamt = in_shamt;
      assign src_op    = in_op;
      assign src_sign  = in_data[WIDTH-1];
      assign src_tag   = in_tag;
    end else begin : g_src_prev
      assign src_valid = g_stage[s-1].valid_q;
      assign src_data  = g_stage[s-1].data_q;
      assign src_shamt = g_stage[s-1].g_ctrl.shamt_q;
      assign src_op    = g_stage[s-1].g_ctrl.op_q;
      assign src_sign  = g_stage[s-1].g_ctrl.sign_q;
      assign src_tag   = g_stage[s-1].tag_q;
    end

    assign chain[0] = src_data;

    for (genvar j = 0; j < LEVELS_PER_STAGE; j++) begin : g_lvl
      if (j < WS) begin : g_mux
        shift_level #(
          .WIDTH(WIDTH),
          .DIST (1 << (s * LEVELS_PER_STAGE + j))
        ) u_level (
          .din (chain[j]),
          .sel (src_shamt[j]),
          .op  (src_op),
          .sign(src_sign),
          .dout(chain[j+1])
        );
      end else begin : g_pass
        assign chain[j+1] = chain[j];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else if (advance) begin
        valid_q <= src_valid;
        data_q  <= chain[LEVELS_PER_STAGE];
        tag_q   <= src_tag;
      end
    end

    // Control for later levels; the last stage has nothing left to carry.
    if (s < NSTAGE - 1) begin : g_ctrl
      localparam int unsigned RS = WS - LEVELS_PER_STAGE;

      logic [RS-1:0] shamt_q;
      logic [1:0]    op_q;
      logic          sign_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shamt_q <= '0;
          op_q    <= SH_OP_SLL;
          sign_q  <= 1'b0;
        end else if (advance) begin
          shamt_q <= src_shamt[WS-1:LEVELS_PER_STAGE];
          op_q    <= src_op;
          sign_q  <= src_sign;
        end
      end
    end
  end

  assign out_valid = g_stage[NSTAGE-1].valid_q;
  assign out_data  = g_stage[NSTAGE-1].data_q;
  assign out_tag   = g_stage[NSTAGE-1].tag_q;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: 32-bit/2-level and 8-bit/1-level instances.
// Expected rotate results follow SHIFTER_ROTATE_EN.
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  localparam int NST = 3;

`ifdef SHIFTER_ROTATE_EN
  localparam logic [31:0] ROR32_EXP = 32'hF000_0000;
  localparam logic [7:0]  ROR8_EXP  = 8'hC8;
`else
  localparam logic [31:0] ROR32_EXP = 32'h0000_0000;
  localparam logic [7:0]  ROR8_EXP  = 8'h48;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag, out_tag;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_shamt8;
  logic [1:0]  in_op8;
  logic [3:0]  in_tag8, out_tag8;

  pipelined_barrel_shifter #(
    .WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(4)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  pipelined_barrel_shifter #(
    .WIDTH(8), .LEVELS_PER_STAGE(1), .TAG_W(4)
  ) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_shamt(in_shamt8),
    .in_op(in_op8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_tag(out_tag8)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          acc;
    bit          chk_lat;
    bit          chk_seq;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  exp_t mon_e;
  exp_t mon_e8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pop = -10;

  logic [31:0] sll_tbl [8] = '{32'h0000_00FF, 32'h0000_0FF0, 32'h0000_FF00, 32'h000F_F000,
                               32'h00FF_0000, 32'h0FF0_0000, 32'hFF00_0000, 32'hF000_0000};
  logic [31:0] sra_tbl [8] = '{32'hF000_0000, 32'hF800_0000, 32'hFC00_0000, 32'hFE00_0000,
                               32'hFF00_0000, 32'hFF80_0000, 32'hFFC0_0000, 32'hFFE0_0000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got tag %0h data %0h, expected no result",
                 out_tag, out_data);
      end else begin
        mon_e = q.pop_front();
        check("out_data", 64'(out_data), 64'(mon_e.data));
        check("out_tag", 64'(out_tag), 64'(mon_e.tag));
        if (mon_e.chk_lat) check("latency", 64'(cyc - mon_e.acc), 64'(NST));
        if (mon_e.chk_seq) check("consecutive", 64'(cyc - last_pop), 64'd1);
      end
      last_pop = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result8: got tag %0h data %0h, expected no result",
                 out_tag8, out_data8);
      end else begin
        mon_e8 = q8.pop_front();
        check("out_data8", 64'(out_data8), 64'(mon_e8.data));
        check("out_tag8", 64'(out_tag8), 64'(mon_e8.tag));
        check("latency8", 64'(cyc - mon_e8.acc), 64'(NST));
      end
    end
  end

  // Holds the op on the input until accepted; caller deasserts in_valid via idle().
  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                      input logic [3:0] t, input logic [31:0] expv, input bit lat,
                      input bit seq);
    int waits;
    bit done;
    bit rdy;
    waits = 0;
    done  = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    in_tag   = t;
    while (!done) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1;
        q.push_back('{data: expv, tag: t, acc: cyc, chk_lat: lat, chk_seq: seq});
      end else if (++waits > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no in_ready, expected accept of tag %0h", t);
        done = 1;
      end
    end
    #1;
  endtask

  task automatic send8(input logic [1:0] op, input logic [7:0] d, input logic [2:0] sh,
                       input logic [3:0] t, input logic [7:0] expv);
    bit rdy;
    in_valid8 = 1'b1;
    in_op8    = op;
    in_data8  = d;
    in_shamt8 = sh;
    in_tag8   = t;
    @(negedge clk);
    rdy = in_ready8;
    @(posedge clk);
    check("accept8", 64'(rdy), 64'd1);
    if (rdy) q8.push_back('{data: 32'(expv), tag: t, acc: cyc, chk_lat: 1, chk_seq: 0});
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() > 0 || q8.size() > 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(q.size() + q8.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic        snap_v;
  logic [31:0] snap_d;
  logic [3:0]  snap_t;

  initial begin
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_op8 = '0; in_tag8 = '0;
    out_ready8 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed single operations, issued back to back.
    send(SH_OP_SRL, 32'h8000_0000, 5'd4,  4'h1, 32'h0800_0000, 1, 0);
    send(SH_OP_SRA, 32'h8000_0000, 5'd4,  4'h2, 32'hF800_0000, 1, 0);
    send(SH_OP_SLL, 32'h0000_0001, 5'd31, 4'h3, 32'h8000_0000, 1, 0);
    send(SH_OP_SLL, 32'hDEAD_BEEF, 5'd0,  4'h4, 32'hDEAD_BEEF, 1, 0);
    send(SH_OP_ROR, 32'h0000_000F, 5'd4,  4'h5, ROR32_EXP,     1, 0);
    send(SH_OP_SRA, 32'h8000_0000, 5'd31, 4'h6, 32'hFFFF_FFFF, 1, 0);
    send(SH_OP_SRA, 32'h7FFF_FFFF, 5'd31, 4'h7, 32'h0000_0000, 1, 0);
    send(SH_OP_ROR, 32'h0000_000F, 5'd0,  4'h8, 32'h0000_000F, 1, 0);
    send(SH_OP_SRA, 32'hDEAD_BEEF, 5'd0,  4'h9, 32'hDEAD_BEEF, 1, 0);
    idle();
    wait_drain();

    // Eight back-to-back ops: results must appear on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      send(SH_OP_SLL, 32'h0000_00FF, 5'(i * 4), 4'(i), sll_tbl[i], 1, i > 0);
    end
    idle();
    wait_drain();

    // Output stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(SH_OP_SRA, 32'hF000_0000, 5'(i), 4'(8 + i), sra_tbl[i], 0, 0);
        end
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        snap_v = out_valid;
        snap_d = out_data;
        snap_t = out_tag;
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_valid_stable", 64'(out_valid), 64'(snap_v));
          check("stall_data_stable", 64'(out_data), 64'(snap_d));
          check("stall_tag_stable", 64'(out_tag), 64'(snap_t));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset with operations in flight.
    send(SH_OP_SRL, 32'h0000_F000, 5'd8, 4'h1, 32'h0000_00F0, 1, 0);
    send(SH_OP_SRL, 32'h0000_F000, 5'd4, 4'h2, 32'h0000_0F00, 1, 0);
    send(SH_OP_SRL, 32'h0000_F000, 5'd0, 4'h3, 32'h0000_F000, 1, 0);
    idle();
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out_valid", 64'(out_valid), 64'd0);
    check("async_reset_out_data", 64'(out_data), 64'd0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("no_stale_result", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(SH_OP_SLL, 32'h0000_0003, 5'd5, 4'hA, 32'h0000_0060, 1, 0);
    idle();
    wait_drain();

    // 8-bit instance, one level per stage.
    send8(SH_OP_SRA, 8'h90, 3'd7, 4'h1, 8'hFF);
    send8(SH_OP_SRL, 8'h90, 3'd7, 4'h2, 8'h01);
    send8(SH_OP_SLL, 8'h90, 3'd3, 4'h3, 8'h80);
    send8(SH_OP_ROR, 8'h91, 3'd1, 4'h4, ROR8_EXP);
    send8(SH_OP_SRA, 8'h90, 3'd0, 4'h5, 8'h90);
    idle();
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter for the datapath/ALU. Generation after the single-cycle 32-bit logical-right shifter.
- Supports SLL, SRL, SRA and optional rotate-right over a WIDTH-bit operand.
- Uses log2(WIDTH) mux levels, with a pipeline register inserted every LEVELS_PER_STAGE levels.
- Valid/ready handshake on input and output, so it can sit in a multi-cycle or pipelined execute stage.

Parameters:
- WIDTH, 32, operand width in bits. Power of two, 8..64.
- SHAMT_W, $clog2(WIDTH), shift-amount width. Derived; do not override.
- LEVELS_PER_STAGE, 2, mux levels between pipeline registers, 1..SHAMT_W.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operation present on the input
- in_ready  output  1  shifter accepts the input this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount
- in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- in_tag  input  TAG_W  sideband tag, returned unchanged
- out_valid  output  1  result present on the output
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  shifted result
- out_tag  output  TAG_W  tag of the result

Behaviour:
- NSTAGE = ceil(SHAMT_W / LEVELS_PER_STAGE). Latency is NSTAGE cycles from accept (in_valid & in_ready) to out_valid, with no stall.
- Level k (k = 0..SHAMT_W-1) shifts by 2^k when shamt[k] = 1. Levels are applied LSB-first.
- Fill values:
  - SLL: 0 from the LSB side.
  - SRL: 0 from the MSB side.
  - SRA: the original operand MSB from the MSB side. This sign bit is captured at accept and carried through the pipe.
  - ROR: wrapped bits.
- Each stage register holds valid, partial data, remaining shamt bits, op, sign and tag.
- Advance rule: advance = out_ready | ~out_valid.
  - When advance is high, every stage loads from its predecessor; stage 0 loads the input.
  - in_ready = advance, combinational. This is a global stall; bubbles are not compressed.
- Input with in_valid = 0 while advance = 1 inserts a bubble (valid = 0).
- Stall: out_data, out_tag and out_valid hold stable while out_valid & ~out_ready.
- Boundary cases:
  - shamt = 0 passes data unchanged for all ops.
  - shamt = WIDTH-1 with SRA yields all sign bits.
- Back-to-back throughput is one operation per cycle while out_ready = 1.
- Reset (async, any time, including mid-operation):
  - All stage valids and out_valid go to 0; out_data and out_tag go to 0.
  - In-flight operations are dropped; no partial result appears after reset release.
  - in_ready = 1 the first cycle after reset deasserts.
- in_data, in_shamt, in_op and in_tag are don't-care when in_valid = 0.

Optional Feature:
- Macro: SHIFTER_ROTATE_EN.
- Defined: op 11 performs rotate-right by shamt.
- Undefined: op 11 is decoded as SRL, so out_data matches the op 01 result; the rotate wrap muxing is not synthesised.

Decomposition:
- Shared package shifter_pkg:
  - op encoding constants SH_OP_SLL = 2'b00, SH_OP_SRL = 2'b01, SH_OP_SRA = 2'b10, SH_OP_ROR = 2'b11.
  - Function computing NSTAGE from SHAMT_W and LEVELS_PER_STAGE.
- Sub-module shift_level:
  - Purely combinational, one mux level, parametrised by WIDTH and DIST = 2^k.
  - Inputs: data, select bit, op, sign. Output: data.
  - Instantiated SHAMT_W times via generate.
- Pipeline registers and handshake live in the top module.

Test Plan:
- WIDTH=32, LEVELS_PER_STAGE=2 (NSTAGE=3):
  - SRL in_data=0x80000000, shamt=4 -> 0x08000000 after 3 cycles, tag echoed.
  - SRA in_data=0x80000000, shamt=4 -> 0xF8000000.
  - SLL in_data=0x00000001, shamt=31 -> 0x80000000.
  - SLL in_data=0xDEADBEEF, shamt=0 -> 0xDEADBEEF.
- ROR in_data=0x0000000F, shamt=4:
  - SHIFTER_ROTATE_EN defined -> 0xF0000000.
  - Undefined -> 0x00000000.
- Stream 8 back-to-back ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order, tags 0..7. Then hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, outputs stable, no loss or duplication after release.
- Assert rst asynchronously (mid-cycle) with 3 ops in flight -> out_valid=0 immediately; after release no stale results emerge and the first new op returns correctly.
- WIDTH=8, LEVELS_PER_STAGE=1 (NSTAGE=3): SRA in_data=0x90, shamt=7 -> 0xFF; SRL in_data=0x90, shamt=7 -> 0x01.
